// File: rtl/supercar_trail_pwm.sv
// Supercar light-bar trail stage: per-LED brightness with fading afterglow, driven as PWM.
// Define SUPERCAR_TRAIL_EXP_DECAY_EN to halve brightness per decay step instead of decrementing.
module supercar_trail_pwm #(
  parameter int N_BIT     = 4,
  parameter int BR_BITS   = 4,
  parameter int DECAY_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_BIT-1:0] pin,
  output logic [N_BIT-1:0] led,
  output logic             frame
);

  localparam int MAX   = (1 << BR_BITS) - 1;
  localparam int DEC_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [BR_BITS-1:0] PWM_LAST = BR_BITS'(MAX - 1);
  localparam logic [BR_BITS-1:0] BR_FULL  = BR_BITS'(MAX);
  localparam logic [DEC_W-1:0]   DEC_LAST = DEC_W'(DECAY_DIV - 1);

  logic [BR_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
  logic [BR_BITS-1:0] br_q [N_BIT];
  logic [BR_BITS-1:0] br_d [N_BIT];
  logic [N_BIT-1:0]   led_q, led_d;
  logic               frame_q, frame_d;
  logic               wrap;
  logic               step;

  function automatic logic [BR_BITS-1:0] decay(input logic [BR_BITS-1:0] b);
`ifdef SUPERCAR_TRAIL_EXP_DECAY_EN
    return b >> 1;
`else
    return b - BR_BITS'(1);
`endif
  endfunction

  always_comb begin
    wrap      = (pwm_cnt_q == PWM_LAST);
    step      = wrap && (dec_cnt_q == DEC_LAST);
    pwm_cnt_d = pwm_cnt_q;
    dec_cnt_d = dec_cnt_q;
    led_d     = led_q;
    frame_d   = frame_q;
    br_d      = br_q;
    if (en) begin
      pwm_cnt_d = wrap ? '0 : pwm_cnt_q + BR_BITS'(1);
      frame_d   = wrap;
      if (wrap) begin
        dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0 : dec_cnt_q + DEC_W'(1);
      end
      for (int unsigned i = 0; i < N_BIT; i++) begin
        // led uses the pre-update brightness, so a load shows one edge later
        led_d[i] = (br_q[i] > pwm_cnt_q);
        if (pin[i]) begin
          br_d[i] = BR_FULL;
        end else if (step && (br_q[i] != '0)) begin
          br_d[i] = decay(br_q[i]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt_q <= '0;
      dec_cnt_q <= '0;
      led_q     <= '0;
      frame_q   <= 1'b0;
      for (int unsigned i = 0; i < N_BIT; i++) begin
        br_q[i] <= '0;
      end
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      led_q     <= led_d;
      frame_q   <= frame_d;
      for (int unsigned i = 0; i < N_BIT; i++) begin
        br_q[i] <= br_d[i];
      end
    end
  end

  assign led   = led_q;
  assign frame = frame_q;

endmodule
